tdc_hw_accum: RTL

- Sits directly downstream of the TDC pop-count stage, in the `clk_capture` domain.
- Consumes the per-sample Hamming weight (`hw`) and its valid strobe.
- Accumulates a window of 2^LOG2_SAMPLES valid samples, then presents sum, mean, min and max as one result word.
- Result handshake is valid/ready, so a slow readout (scan chain / SPI shim) can drain it.

---
 rtl/tdc_hw_accum.sv | 94 +++++++++
 1 files changed

// File: rtl/tdc_hw_accum.sv
// tdc_hw_accum: windowed sum/mean/min/max of TDC Hamming weights (TDC_HW_ACCUM_AUTORESTART_EN: back-to-back windows)
module tdc_hw_accum #(
  parameter int N = 64,
  parameter int LOG2_SAMPLES = 8,
  localparam int HW_W = $clog2(N) + 1,
  localparam int SUM_W = HW_W + LOG2_SAMPLES
) (
  input  logic             clk_capture,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             val_in,
  input  logic [HW_W-1:0]  hw_in,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SUM_W-1:0] res_sum,
  output logic [HW_W-1:0]  res_mean,
  output logic [HW_W-1:0]  res_min,
  output logic [HW_W-1:0]  res_max,
  output logic             overrun
);
  localparam int CNT_W = LOG2_SAMPLES + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** LOG2_SAMPLES) - 1);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
`ifdef TDC_HW_ACCUM_AUTORESTART_EN
  localparam state_t AFTER_HS = ACCUM;
`else
  localparam state_t AFTER_HS = IDLE;
`endif
  state_t state, nxt_state;
  logic [SUM_W-1:0] sum, nxt_sum;
  logic [HW_W-1:0] run_min, run_max, nxt_min, nxt_max;
  logic [CNT_W-1:0] count;
  logic acc, last, hs, open_win, init;
  always_comb begin
    acc = state == ACCUM && en && val_in;
    last = acc && count == CNT_LAST;
    hs = state == HOLD && res_ready;
    open_win = state == IDLE && start;
`ifdef TDC_HW_ACCUM_AUTORESTART_EN
    init = open_win || hs;
`else
    init = open_win;
`endif
    nxt_sum = sum + SUM_W'(hw_in);
    nxt_min = hw_in < run_min ? hw_in : run_min;
    nxt_max = hw_in > run_max ? hw_in : run_max;
    nxt_state = state == IDLE  ? (start ? ACCUM : IDLE) :
                state == ACCUM ? (last ? HOLD : ACCUM) :
                                 (hs ? AFTER_HS : HOLD);
  end
  assign busy = state == ACCUM;
  assign res_valid = state == HOLD;
  always_ff @(posedge clk_capture) begin
    if (rst) begin
      state <= IDLE;
      sum <= '0;
      count <= '0;
      run_min <= '0;
      run_max <= '0;
      res_sum <= '0;
      res_mean <= '0;
      res_min <= '0;
      res_max <= '0;
      overrun <= 1'b0;
    end else begin
      state <= nxt_state;
      if (init) begin
        sum <= '0;
        count <= '0;
        run_min <= HW_W'(N);
        run_max <= '0;
      end else if (acc) begin
        sum <= nxt_sum;
        count <= last ? '0 : count + 1'b1;
        run_min <= nxt_min;
        run_max <= nxt_max;
      end
      if (last) begin
        res_sum <= nxt_sum;
        res_mean <= HW_W'(nxt_sum >> LOG2_SAMPLES);
        res_min <= nxt_min;
        res_max <= nxt_max;
      end
      // only a start taken in IDLE clears overrun, so autorestart keeps it sticky
      if (open_win) overrun <= 1'b0;
      else if (en && val_in && state != ACCUM) overrun <= 1'b1;
    end
  end
  a_res_stable: assert property (@(posedge clk_capture) disable iff (rst)
    res_valid && !res_ready |=> $stable(res_sum) && $stable(res_mean) && $stable(res_min) && $stable(res_max));
  a_count_max: assert property (@(posedge clk_capture) disable iff (rst) count <= CNT_LAST);
endmodule
